// File: rtl/proj_fm_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | proj_fm_pkg                                                           |
// | Shared sizing for the feature-map read-side serializer.               |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package proj_fm_pkg;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int FM_BUFFER_COUNT         = 2;
  localparam int FM_RAMS                 = 2;
  localparam int FM_ENTRIES              = 2;
  localparam int FM_OFFSET               = 2;
  localparam int FM_DATA_BITS            = 8;
  localparam int FM_READ_ADDRESSES_COUNT = 2;

  localparam int FRAME_WORDS     = FM_RAMS * FM_ENTRIES * FM_OFFSET;
  localparam int BEATS_PER_FRAME = FRAME_WORDS / FM_READ_ADDRESSES_COUNT;
  localparam int WORD_CNT_W      = clog2_min1(FRAME_WORDS);
  localparam int LANE_CNT_W      = clog2_min1(FM_READ_ADDRESSES_COUNT);
  localparam int BUF_IDX_W       = clog2_min1(FM_BUFFER_COUNT);

  typedef logic [FM_DATA_BITS-1:0] word_t;

endpackage
`default_nettype wire

// File: rtl/proj_fm_frame_counter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | proj_fm_frame_counter                                                 |
// | Word-in-frame counter and ping-pong buffer index with abort handling. |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module proj_fm_frame_counter #(
  parameter int BUFFER_COUNT = 2,
  parameter int FRAME_WORDS  = 8,
  parameter int WORD_W       = 3,
  parameter int BUF_W        = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_hs,
  input  logic             i_abort,
  input  logic             i_hold_full,
  output logic             o_at_last,
  output logic [BUF_W-1:0] o_buf_idx
);

  logic [WORD_W-1:0] r_word_cnt;
  logic [BUF_W-1:0]  r_buf_idx;
  logic [BUF_W-1:0]  w_buf_next;
  logic              w_at_last;

  assign w_at_last  = (r_word_cnt == WORD_W'(FRAME_WORDS - 1));
  assign w_buf_next = (r_buf_idx == BUF_W'(BUFFER_COUNT - 1)) ? '0 : r_buf_idx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word_cnt <= '0;
      r_buf_idx  <= '0;
    end else if (i_abort) begin
      r_word_cnt <= '0;
      // An idle, frame-aligned abort has nothing to drop, so the buffer stays.
      if ((r_word_cnt != '0) || i_hold_full) begin
        r_buf_idx <= w_buf_next;
      end
    end else if (i_hs) begin
      if (w_at_last) begin
        r_word_cnt <= '0;
        r_buf_idx  <= w_buf_next;
      end else begin
        r_word_cnt <= r_word_cnt + 1'b1;
      end
    end
  end

  assign o_at_last = w_at_last;
  assign o_buf_idx = r_buf_idx;

endmodule
`default_nettype wire

// File: rtl/proj_fm_serializer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | proj_fm_serializer                                                    |
// | Wide FM RAM read beats in, one word per handshake out, frame-tagged.  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module proj_fm_serializer
  import proj_fm_pkg::*;
#(
  parameter int  BUFFER_COUNT         = FM_BUFFER_COUNT,
  parameter int  RAMS                 = FM_RAMS,
  parameter int  ENTRIES              = FM_ENTRIES,
  parameter int  OFFSET               = FM_OFFSET,
  parameter int  DATA_BITS            = FM_DATA_BITS,
  parameter int  READ_ADDRESSES_COUNT = FM_READ_ADDRESSES_COUNT,
  localparam int BUF_W                = clog2_min1(BUFFER_COUNT)
) (
  input  logic                                      in_clk,
  input  logic                                      in_rst_n,
  input  logic [READ_ADDRESSES_COUNT*DATA_BITS-1:0] in_rdata,
  input  logic                                      in_valid,
  output logic                                      out_ready,
  input  logic                                      in_abort,
  output logic [DATA_BITS-1:0]                      out_data,
  output logic                                      out_valid,
  input  logic                                      in_ready,
  output logic                                      out_last,
  output logic [BUF_W-1:0]                          out_buf_idx
);

  localparam int C_FRAME_WORDS = RAMS * ENTRIES * OFFSET;
  localparam int C_WORD_W      = clog2_min1(C_FRAME_WORDS);
  localparam int C_LANE_W      = clog2_min1(READ_ADDRESSES_COUNT);

  if ((C_FRAME_WORDS % READ_ADDRESSES_COUNT) != 0) begin : g_bad_lane_count
    $error("READ_ADDRESSES_COUNT must divide RAMS*ENTRIES*OFFSET");
  end

  logic [READ_ADDRESSES_COUNT-1:0][DATA_BITS-1:0] r_hold;
  logic                                           r_full;
  logic [C_LANE_W-1:0]                            r_lane;
  logic                                           w_lane_last;
  logic                                           w_hs;
  logic                                           w_accept;
  logic                                           w_at_last;

  assign w_lane_last = (r_lane == C_LANE_W'(READ_ADDRESSES_COUNT - 1));
  assign w_hs        = r_full & in_ready & ~in_abort;
  // Combinational in_ready -> out_ready lets the next beat load as the last lane leaves.
  assign out_ready   = ~in_abort & (~r_full | (w_lane_last & r_full & in_ready));
  assign w_accept    = in_valid & out_ready;

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      r_hold <= '0;
      r_full <= 1'b0;
      r_lane <= '0;
    end else if (in_abort) begin
      r_full <= 1'b0;
      r_lane <= '0;
    end else if (w_accept) begin
      r_hold <= in_rdata;
      r_full <= 1'b1;
      r_lane <= '0;
    end else if (w_hs) begin
      if (w_lane_last) begin
        r_full <= 1'b0;
        r_lane <= '0;
      end else begin
        r_lane <= r_lane + 1'b1;
      end
    end
  end

  proj_fm_frame_counter #(
    .BUFFER_COUNT (BUFFER_COUNT),
    .FRAME_WORDS  (C_FRAME_WORDS),
    .WORD_W       (C_WORD_W),
    .BUF_W        (BUF_W)
  ) u_frame_counter (
    .clk         (in_clk),
    .rst_n       (in_rst_n),
    .i_hs        (w_hs),
    .i_abort     (in_abort),
    .i_hold_full (r_full),
    .o_at_last   (w_at_last),
    .o_buf_idx   (out_buf_idx)
  );

  assign out_valid = r_full;
  assign out_data  = r_full ? r_hold[r_lane] : '0;
  assign out_last  = w_at_last & r_full;

endmodule
`default_nettype wire

// File: tb/tb_proj_fm_serializer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_proj_fm_serializer                                                 |
// | Directed and randomized stimulus against a word-queue reference model.|
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_proj_fm_serializer;
  import proj_fm_pkg::*;

  localparam int RAC = FM_READ_ADDRESSES_COUNT;
  localparam int DB  = FM_DATA_BITS;
  localparam int BC  = FM_BUFFER_COUNT;

  logic                 clk;
  logic                 in_rst_n;
  logic [RAC*DB-1:0]    in_rdata;
  logic                 in_valid;
  logic                 out_ready;
  logic                 in_abort;
  logic [DB-1:0]        out_data;
  logic                 out_valid;
  logic                 in_ready;
  logic                 out_last;
  logic [BUF_IDX_W-1:0] out_buf_idx;

  proj_fm_serializer #(
    .BUFFER_COUNT         (BC),
    .RAMS                 (FM_RAMS),
    .ENTRIES              (FM_ENTRIES),
    .OFFSET               (FM_OFFSET),
    .DATA_BITS            (DB),
    .READ_ADDRESSES_COUNT (RAC)
  ) dut (
    .in_clk      (clk),
    .in_rst_n    (in_rst_n),
    .in_rdata    (in_rdata),
    .in_valid    (in_valid),
    .out_ready   (out_ready),
    .in_abort    (in_abort),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .in_ready    (in_ready),
    .out_last    (out_last),
    .out_buf_idx (out_buf_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: words still owed downstream, position in frame, buffer index.
  word_t             q[$];
  int                wcnt = 0;
  int                bidx = 0;
  logic [RAC*DB-1:0] cur_beat;
  bit                seq_mode = 1'b1;
  int                src = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic make_beat();
    for (int k = 0; k < RAC; k++) begin
      if (seq_mode) cur_beat[k*DB +: DB] = word_t'(src + k);
      else          cur_beat[k*DB +: DB] = word_t'($urandom);
    end
  endtask

  task automatic step(input bit v, input bit rdy, input bit ab);
    bit e_valid, e_last, e_ready, acc, hs;
    @(negedge clk);
    in_valid = v;
    in_ready = rdy;
    in_abort = ab;
    in_rdata = cur_beat;
    #1;
    e_valid = (q.size() != 0);
    e_last  = e_valid && (wcnt == FRAME_WORDS - 1);
    e_ready = !ab && ((q.size() == 0) || ((q.size() == 1) && rdy));
    chk("out_valid", out_valid, e_valid);
    chk("out_last", out_last, e_last);
    chk("out_buf_idx", out_buf_idx, bidx);
    chk("out_ready", out_ready, e_ready);
    if (e_valid) chk("out_data", out_data, q[0]);
    acc = v && e_ready;
    hs  = e_valid && rdy && !ab;
    @(posedge clk);
    if (ab) begin
      if (!(wcnt == 0 && q.size() == 0)) bidx = (bidx + 1) % BC;
      wcnt = 0;
      q.delete();
    end else begin
      if (hs) begin
        void'(q.pop_front());
        if (wcnt == FRAME_WORDS - 1) begin
          wcnt = 0;
          bidx = (bidx + 1) % BC;
        end else begin
          wcnt++;
        end
      end
      if (acc) begin
        for (int k = 0; k < RAC; k++) q.push_back(cur_beat[k*DB +: DB]);
        src += RAC;
        make_beat();
      end
    end
  endtask

  // Reset lands between clock edges; outputs must clear without waiting for a clock.
  task automatic async_reset();
    #2;
    in_valid = 1'b0;
    in_ready = 1'b0;
    in_abort = 1'b0;
    in_rst_n = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, '0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_out_buf_idx", out_buf_idx, '0);
    q.delete();
    wcnt = 0;
    bidx = 0;
    @(negedge clk);
    in_rst_n = 1'b1;
  endtask

  task automatic restart_seq();
    seq_mode = 1'b1;
    src      = 0;
    make_beat();
  endtask

  initial begin
    in_rst_n = 1'b0;
    in_valid = 1'b0;
    in_ready = 1'b0;
    in_abort = 1'b0;
    in_rdata = '0;
    restart_seq();
    @(posedge clk);
    async_reset();

    // First frame: 00..07 back to back, last on 07, buffer 0 then 1.
    restart_seq();
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0);

    // Eight more frames of random data at full rate.
    seq_mode = 1'b0;
    make_beat();
    for (int i = 0; i < 8 * FRAME_WORDS; i++) step(1'b1, 1'b1, 1'b0);

    // Stall three cycles on word 0x03, then release.
    async_reset();
    restart_seq();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0);

    // Abort right after word 0x02, then a full clean frame.
    async_reset();
    restart_seq();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < FRAME_WORDS + 4; i++) step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);

    // Reset in the middle of a frame, then resume.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0);
    async_reset();
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0);

    // Upstream offers a beat only every other cycle.
    for (int i = 0; i < 40; i++) step(i % 2 == 0, 1'b1, 1'b0);

    // Random valid/ready/abort mix.
    seq_mode = 1'b0;
    for (int i = 0; i < 500; i++) begin
      step(($urandom % 4) != 0, ($urandom % 4) != 0, ($urandom % 40) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
